// File: rtl/vga_timing_receiver_pkg.sv
// rtl/vga_timing_receiver_pkg.sv - shared VGA timing defaults and counter helpers
package vga_timing_receiver_pkg;

  // Same defaults the generator and sprite blocks use, so all ends agree on geometry.
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_TOTAL   = 800;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_TOTAL   = 525;
  localparam int unsigned VGA_CNT_MAX   = 1023;

  typedef logic [9:0] vga_cnt_t;

  function automatic vga_cnt_t sat_inc(input vga_cnt_t v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_sync.sv
// rtl/vga_edge_sync.sv - two-stage input register with rise/fall pulses
module vga_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic s1,
  output logic s2,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

endmodule

// File: rtl/vga_timing_receiver.sv
// rtl/vga_timing_receiver.sv - rebuilds beam X/Y from VGA timing and tracks lock
module vga_timing_receiver
  import vga_timing_receiver_pkg::*;
#(
  parameter int unsigned p_H_VISIBLE    = VGA_H_VISIBLE,
  parameter int unsigned p_H_TOTAL      = VGA_H_TOTAL,
  parameter int unsigned p_V_VISIBLE    = VGA_V_VISIBLE,
  parameter int unsigned p_V_TOTAL      = VGA_V_TOTAL,
  parameter logic        p_HSYNC_ACTIVE = 1'b0,
  parameter int unsigned p_LOCK_FRAMES  = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_HSync,
  input  logic       i_HBlank,
  input  logic       i_VBlank,
  output logic [9:0] o_X,
  output logic [9:0] o_Y,
  output logic       o_Visible,
  output logic       o_Frame_Start,
  output logic       o_Locked,
  output logic       o_Error
);

  if (p_H_VISIBLE > VGA_CNT_MAX || p_H_TOTAL > VGA_CNT_MAX || p_V_VISIBLE > VGA_CNT_MAX ||
      p_V_TOTAL > VGA_CNT_MAX || p_LOCK_FRAMES > VGA_CNT_MAX) begin : g_param_check
    $error("vga_timing_receiver: geometry parameters must not exceed 1023");
  end

  localparam vga_cnt_t H_VIS_M1 = 10'(p_H_VISIBLE - 1);
  localparam vga_cnt_t H_TOT_M1 = 10'(p_H_TOTAL - 1);
  localparam vga_cnt_t V_VIS    = 10'(p_V_VISIBLE);
  localparam vga_cnt_t V_TOT_M1 = 10'(p_V_TOTAL - 1);
  localparam vga_cnt_t LOCK_N   = 10'(p_LOCK_FRAMES);
  localparam vga_cnt_t H_VIS    = 10'(p_H_VISIBLE);

  typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

  logic hb_s1, hb_s2, hb_rise, hb_fall;
  logic vb_s1, vb_s2, vb_rise, vb_fall;
  logic hs_s1, hs_s2, hs_rise, hs_fall;

  vga_edge_sync u_hblank (.clk(i_Clk), .rst_n(i_Rst_n), .din(i_HBlank),
                          .s1(hb_s1), .s2(hb_s2), .rise(hb_rise), .fall(hb_fall));
  vga_edge_sync u_vblank (.clk(i_Clk), .rst_n(i_Rst_n), .din(i_VBlank),
                          .s1(vb_s1), .s2(vb_s2), .rise(vb_rise), .fall(vb_fall));
  vga_edge_sync u_hsync  (.clk(i_Clk), .rst_n(i_Rst_n), .din(i_HSync),
                          .s1(hs_s1), .s2(hs_s2), .rise(hs_rise), .fall(hs_fall));

  logic unused_edges;
  assign unused_edges = ^{hb_s2, vb_s2, vb_rise, hs_s2};

  state_t   state, state_nxt;
  vga_cnt_t x_cnt, y_cnt, vis_lines, frame_cnt, frame_nxt;
  logic     vfall_pend, rise_seen, rise_err, sync_err;
  logic [1:0] sync_cnt;

  logic sync_on, sync_start, y_load, line_err, frame_err, violation;

  assign sync_on    = (hs_s1 == p_HSYNC_ACTIVE);
  assign sync_start = p_HSYNC_ACTIVE ? hs_rise : hs_fall;
  // A VBlank fall in the same cycle as the HBlank fall makes that very line Y=0.
  assign y_load     = hb_fall & (vb_fall | vfall_pend);
  assign line_err   = hb_fall & ((x_cnt != H_TOT_M1) | ~rise_seen | rise_err |
                                 (sync_cnt != 2'd1) | sync_err);
  assign frame_err  = y_load & ((y_cnt != V_TOT_M1) | (vis_lines != V_VIS));
  assign violation  = line_err | frame_err;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= ST_SEARCH;
      frame_cnt  <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      vis_lines  <= '0;
      vfall_pend <= 1'b0;
      rise_seen  <= 1'b0;
      rise_err   <= 1'b0;
      sync_cnt   <= '0;
      sync_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_nxt;
      x_cnt     <= hb_fall ? '0 : sat_inc(x_cnt);
      if (hb_fall) begin
        y_cnt      <= y_load ? '0 : sat_inc(y_cnt);
        vis_lines  <= y_load ? {9'd0, ~vb_s1} : (vb_s1 ? vis_lines : sat_inc(vis_lines));
        vfall_pend <= 1'b0;
        rise_seen  <= 1'b0;
        rise_err   <= 1'b0;
        sync_cnt   <= {1'b0, sync_start};
        sync_err   <= sync_on;
      end else begin
        if (vb_fall) vfall_pend <= 1'b1;
        if (hb_rise) begin
          rise_seen <= 1'b1;
          if (rise_seen || x_cnt != H_VIS_M1) rise_err <= 1'b1;
        end
        if (sync_start && sync_cnt != 2'd2) sync_cnt <= sync_cnt + 2'd1;
        if (sync_on && !hb_s1) sync_err <= 1'b1;
      end
    end
  end

  // A violation on the same cycle as a lock-qualifying frame end takes priority.
  always_comb begin
    state_nxt = state;
    frame_nxt = frame_cnt;
    case (state)
      ST_SEARCH: begin
        if (y_load) begin
          state_nxt = ST_VERIFY;
          frame_nxt = '0;
        end
      end
      ST_VERIFY: begin
        if (violation) begin
          state_nxt = ST_SEARCH;
        end else if (y_load) begin
          if (frame_cnt + 10'd1 == LOCK_N) state_nxt = ST_LOCKED;
          else                             frame_nxt = frame_cnt + 10'd1;
        end
      end
      ST_LOCKED: begin
        if (violation) state_nxt = ST_SEARCH;
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  assign o_X           = x_cnt;
  assign o_Y           = y_cnt;
  assign o_Locked      = (state == ST_LOCKED);
  assign o_Visible     = o_Locked & (x_cnt < H_VIS) & (y_cnt < V_VIS);
  assign o_Frame_Start = o_Locked & (x_cnt == '0) & (y_cnt == '0);
  assign o_Error       = violation & (state != ST_SEARCH);

endmodule

// File: doc/vga_timing_receiver.md
Name: vga_timing_receiver

Overview:
- Receiver end of the VGA timing interface driven by the Vga generator.
- Consumes the HSync/HBlank/VBlank timing signals and reconstructs the beam position (X/Y) from them.
- Checks the timing against the configured geometry and reports lock and error status.
- Used as an on-chip timing monitor and as a self-checking sink in sprite and ball simulations.

Parameters:
- p_H_VISIBLE, 640, visible pixels per line (HBlank low cycles per line)
- p_H_TOTAL, 800, clocks per line, measured between HBlank falling edges
- p_V_VISIBLE, 480, visible lines per frame (lines with VBlank low)
- p_V_TOTAL, 525, lines per frame
- p_HSYNC_ACTIVE, 0, asserted level of i_HSync
- p_LOCK_FRAMES, 2, consecutive clean frames required to lock

Ports:
- i_Clk  in  1  pixel clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_HSync  in  1  horizontal sync from the timing generator
- i_HBlank  in  1  high during horizontal blanking
- i_VBlank  in  1  high during vertical blanking
- o_X  out  10  reconstructed column; 0 = first visible pixel
- o_Y  out  10  reconstructed line; 0 = first visible line
- o_Visible  out  1  high when o_X < p_H_VISIBLE and o_Y < p_V_VISIBLE and the block is LOCKED
- o_Frame_Start  out  1  one-cycle pulse at X=0, Y=0 while LOCKED
- o_Locked  out  1  high in state LOCKED
- o_Error  out  1  one-cycle pulse on any timing violation

Behaviour:
- Reset (async, i_Rst_n low): o_X=0, o_Y=0, all 1-bit outputs 0, FSM=SEARCH, all counters and input registers cleared.
- Input path:
  - Inputs registered into stage 1; stage 1 copied into stage 2.
  - Edges are detected from stage 1 versus stage 2.
  - All outputs describe the pixel sampled 2 clocks earlier: fixed latency 2.
- Horizontal counter:
  - Loads 0 on an HBlank falling edge, otherwise increments.
  - Saturates at 1023; saturation does not wrap.
- Horizontal checks, at each HBlank falling edge once a previous one has been seen:
  - Line length must equal p_H_TOTAL.
  - The HBlank rising edge must occur after exactly p_H_VISIBLE low cycles.
  - Exactly one HSync assertion must occur per line, entirely while HBlank is high.
- Vertical counter:
  - Increments on each HBlank falling edge.
  - Loads 0 on the first HBlank falling edge after a VBlank falling edge.
  - Saturates at 1023.
- Vertical checks:
  - p_V_VISIBLE lines must start with VBlank low.
  - p_V_TOTAL lines are required between VBlank falling edges.
- FSM:
  - SEARCH: wait for a VBlank falling edge. The first HBlank falling edge after it moves to VERIFY with the frame counter at 0.
  - VERIFY: run all checks. Each completed clean frame increments the frame counter. When the counter reaches p_LOCK_FRAMES, go to LOCKED. Any violation goes to SEARCH.
  - LOCKED: run all checks. Any violation pulses o_Error, deasserts o_Locked on the next cycle, and returns to SEARCH.
- o_Error pulses on violations in VERIFY and in LOCKED only; nothing is flagged in SEARCH.
- o_X and o_Y count in every state; o_Visible and o_Frame_Start are gated by LOCKED.
- Simultaneous events:
  - A VBlank falling edge coinciding with an HBlank falling edge means that line is Y=0.
  - A violation coinciding with a lock-qualifying frame end: the violation wins.
- Reset mid-frame: restart in SEARCH with no error pulse after release.
- Arithmetic: counters are 10-bit unsigned. Comparisons against the parameters are done at 10 bits, so all parameters must be at most 1023 (elaboration check).

Decomposition:
- Shared timing package/include holds the default H/V visible and total values, already used by the generator and sprites, so the generator and receiver cannot drift apart.
- FSM state encodings are local.
- One natural sub-module, vga_edge_sync: 2-stage input register plus rise/fall pulse outputs, instantiated once per timing input.

Test Plan:
- Drive from the Vga generator with default parameters:
  - After reset, o_Locked stays 0 for 2 full frames and asserts within the 3rd frame (by 3×525×800 clocks).
  - o_Error stays 0 throughout.
- Locked run:
  - o_Frame_Start pulses exactly once per 420000 clocks.
  - o_Visible is high for exactly 307200 cycles per frame.
  - At the first visible pixel, o_X=0 and o_Y=0 two cycles after HBlank falls.
- Stretch one line's HBlank high period by 1 clock while LOCKED:
  - o_Error pulses once at the next HBlank falling edge (line length 801).
  - o_Locked drops and re-locks after 2 clean frames.
- Suppress HSync on one line:
  - o_Error pulses at the next HBlank falling edge and the FSM returns to SEARCH.
- Assert i_Rst_n low for 3 clocks mid-line while LOCKED:
  - All outputs are 0 asynchronously, with no o_Error after release.
  - Lock is reacquired normally.
- Supply 524 lines per frame:
  - o_Locked never asserts.
  - o_Error pulses at each frame end while in VERIFY.
